// File: rtl/rob_pkg.sv
// Reorder-buffer commit queue shared definitions.
// Slot state encoding and default widths.
package rob_pkg;

  localparam int TAG_W_DEF  = 3;
  localparam int REG_W_DEF  = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } slot_state_e;

endpackage

// File: rtl/rob_slot.sv
// One reorder-buffer slot: state, destination and result.
// Ports: flush_i, alloc_i/dest_i, cdb_i/cdb_value_i, free_i in; state_o, dest_o, value_o out.
module rob_slot
  import rob_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              alloc_i,
  input  logic [REG_W-1:0]  dest_i,
  input  logic              cdb_i,
  input  logic [DATA_W-1:0] cdb_value_i,
  input  logic              free_i,
  output slot_state_e       state_o,
  output logic [REG_W-1:0]  dest_o,
  output logic [DATA_W-1:0] value_o
);

  slot_state_e       state_q, state_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic [DATA_W-1:0] value_q, value_d;

  // A slot being allocated was FREE, so a same-cycle CDB hit is dropped.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    value_d = value_q;
    if (flush_i) begin
      state_d = FREE;
    end else if (alloc_i) begin
      state_d = BUSY;
      dest_d  = dest_i;
    end else if (cdb_i && state_q == BUSY) begin
      state_d = DONE;
      value_d = cdb_value_i;
    end else if (free_i) begin
      state_d = FREE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FREE;
      dest_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      value_q <= value_d;
    end
  end

  assign state_o = state_q;
  assign dest_o  = dest_q;
  assign value_o = value_q;

endmodule

// File: rtl/rob_commit_queue.sv
// In-order commit queue: allocate at tail, complete via CDB, retire at head.
// Ports: alloc_*, cdb_*, flush in; rf_* write, commit_tag, empty, count out.
module rob_commit_queue
  import rob_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              flush,
  output logic              rf_wen,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [TAG_W-1:0]  commit_tag,
  output logic              empty,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic              wen_q;
  logic [REG_W-1:0]  waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TAG_W-1:0]  ctag_q;

  slot_state_e       st [DEPTH];
  logic [REG_W-1:0]  dst [DEPTH];
  logic [DATA_W-1:0] val [DEPTH];

  logic do_alloc;
  logic do_commit;

  // Ready looks only at registered occupancy: a full queue stays
  // closed even in the cycle its head retires.
  assign alloc_ready = (count_q < FULL) && !flush;
  assign alloc_tag   = tail_q;
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_commit   = !flush && (st[head_q] == DONE);

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    rob_slot #(
      .REG_W  (REG_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .alloc_i     (do_alloc && tail_q == TAG_W'(g)),
      .dest_i      (alloc_dest),
      .cdb_i       (cdb_valid && cdb_tag == TAG_W'(g)),
      .cdb_value_i (cdb_value),
      .free_i      (do_commit && head_q == TAG_W'(g)),
      .state_o     (st[g]),
      .dest_o      (dst[g]),
      .value_o     (val[g])
    );
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_alloc)  tail_d = tail_q + 1'b1;
      if (do_commit) head_d = head_q + 1'b1;
      unique case ({do_alloc, do_commit})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ctag_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wen_q   <= do_commit;
      if (do_commit) begin
        waddr_q <= dst[head_q];
        wdata_q <= val[head_q];
        ctag_q  <= head_q;
      end
    end
  end

  assign rf_wen     = wen_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;
  assign commit_tag = ctag_q;
  assign count      = count_q;
  assign empty      = (count_q == '0);

endmodule

// File: tb/tb_rob_commit_queue.sv
// Bench for rob_commit_queue: directed scenarios plus random traffic
// checked against an in-order queue model.
module tb_rob_commit_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  logic [4:0]  alloc_dest;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        flush;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  commit_tag;
  logic        empty;
  logic [3:0]  count;

  rob_commit_queue #(
    .DEPTH  (8),
    .TAG_W  (3),
    .REG_W  (5),
    .DATA_W (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_valid (alloc_valid),
    .alloc_dest  (alloc_dest),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
    .flush       (flush),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .commit_tag  (commit_tag),
    .empty       (empty),
    .count       (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: in-flight instructions in allocation order.
  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  dest;
    bit          done;
    logic [31:0] val;
  } ent_t;

  ent_t        q[$];
  int          next_tag = 0;
  logic        e_wen    = 0;
  logic [4:0]  e_waddr  = 0;
  logic [31:0] e_wdata  = 0;
  logic [2:0]  e_ctag   = 0;

  logic [4:0]  lg_a[$];
  logic [31:0] lg_d[$];
  int          lg_c[$];
  int          cyc = 0;

  task automatic model_edge();
    if (!rst_n) begin
      q.delete();
      next_tag = 0;
      e_wen = 0; e_waddr = 0; e_wdata = 0; e_ctag = 0;
    end else if (flush) begin
      q.delete();
      next_tag = 0;
      e_wen = 0;
    end else begin
      int  sz;
      bit  cm;
      ent_t e;
      sz = q.size();
      cm = (sz > 0) && q[0].done;
      if (cdb_valid)
        foreach (q[i])
          if (q[i].tag == cdb_tag && !q[i].done) begin
            q[i].done = 1;
            q[i].val  = cdb_value;
          end
      e_wen = cm;
      if (cm) begin
        e_waddr = q[0].dest;
        e_wdata = q[0].val;
        e_ctag  = q[0].tag;
        void'(q.pop_front());
      end
      if (alloc_valid && sz < 8) begin
        e.tag = 3'(next_tag); e.dest = alloc_dest;
        e.done = 0; e.val = 0;
        q.push_back(e);
        next_tag = (next_tag + 1) % 8;
      end
    end
  endtask

  task automatic check_outputs();
    chk("rf_wen",   64'(rf_wen),   64'(e_wen));
    chk("rf_waddr", 64'(rf_waddr), 64'(e_waddr));
    chk("rf_wdata", 64'(rf_wdata), 64'(e_wdata));
    chk("ctag",     64'(commit_tag), 64'(e_ctag));
    chk("count",    64'(count),    64'(q.size()));
    chk("empty",    64'(empty),    64'(q.size() == 0));
    chk("ready",    64'(alloc_ready), 64'(q.size() < 8 && !flush));
    chk("atag",     64'(alloc_tag), 64'(next_tag));
  endtask

  task automatic step();
    #1;
    check_outputs();
    if (rf_wen === 1'b1) begin
      lg_a.push_back(rf_waddr);
      lg_d.push_back(rf_wdata);
      lg_c.push_back(cyc);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    alloc_valid = 0;
    cdb_valid   = 0;
    flush       = 0;
  endtask

  initial begin
    int n0;
    int pick;
    logic [2:0] t;
    rst_n = 0; idle(); alloc_dest = 0; cdb_tag = 0; cdb_value = 0;
    @(negedge clk);
    @(posedge clk); model_edge(); @(negedge clk);
    step();
    rst_n = 1;
    step();
    chk("rst_ready", 64'(alloc_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_atag",  64'(alloc_tag), 64'd0);

    // In-order retirement with out-of-order completion.
    n0 = lg_a.size();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; alloc_dest = 5'(3 + i);
      step();
    end
    idle();
    cdb_valid = 1;
    cdb_tag = 1; cdb_value = 32'hBB; step();
    cdb_tag = 0; cdb_value = 32'hAA; step();
    cdb_tag = 2; cdb_value = 32'hCC; step();
    idle();
    repeat (5) step();
    chk("ord_n", 64'(lg_a.size() - n0), 64'd3);
    if (lg_a.size() - n0 == 3) begin
      chk("ord_a0", 64'(lg_a[n0]),   64'd3);
      chk("ord_d0", 64'(lg_d[n0]),   64'hAA);
      chk("ord_a1", 64'(lg_a[n0+1]), 64'd4);
      chk("ord_d1", 64'(lg_d[n0+1]), 64'hBB);
      chk("ord_a2", 64'(lg_a[n0+2]), 64'd5);
      chk("ord_d2", 64'(lg_d[n0+2]), 64'hCC);
      chk("ord_gap", 64'(lg_c[n0+2] - lg_c[n0]), 64'd2);
    end

    // CDB to a FREE slot is ignored.
    n0 = lg_a.size();
    cdb_valid = 1; cdb_tag = 2; cdb_value = 32'h55;
    step();
    idle();
    repeat (3) step();
    chk("free_cdb_wen", 64'(lg_a.size() - n0), 64'd0);
    chk("free_cdb_cnt", 64'(count), 64'd0);

    // Full queue; held alloc does not slip in on the commit cycle.
    alloc_valid = 1;
    for (int i = 0; i < 8; i++) begin
      alloc_dest = 5'($urandom); step();
    end
    chk("full_cnt",   64'(count), 64'd8);
    chk("full_ready", 64'(alloc_ready), 64'd0);
    cdb_valid = 1; cdb_tag = q[0].tag; cdb_value = $urandom;
    step();
    cdb_valid = 0;
    chk("full_ready2", 64'(alloc_ready), 64'd0);
    step();
    chk("full_cnt7",  64'(count), 64'd7);
    chk("full_ready3", 64'(alloc_ready), 64'd1);
    chk("full_wen",   64'(rf_wen), 64'd1);
    idle();
    flush = 1; step(); idle();

    // 20 alloc/complete/commit rounds; tags wrap.
    for (int i = 0; i < 20; i++) begin
      t = 3'(next_tag);
      alloc_valid = 1; alloc_dest = 5'($urandom); step();
      alloc_valid = 0;
      cdb_valid = 1; cdb_tag = t; cdb_value = $urandom; step();
      cdb_valid = 0; step(); step();
    end

    // Flush beats alloc, CDB and commit.
    idle();
    alloc_valid = 1;
    repeat (4) begin alloc_dest = 5'($urandom); step(); end
    cdb_valid = 1; cdb_tag = q[0].tag; cdb_value = 32'h1234;
    flush = 1; step();
    idle();
    chk("fl_cnt",   64'(count), 64'd0);
    chk("fl_empty", 64'(empty), 64'd1);
    chk("fl_wen",   64'(rf_wen), 64'd0);
    chk("fl_atag",  64'(alloc_tag), 64'd0);
    step();
    chk("fl_wen2",  64'(rf_wen), 64'd0);

    // Reset while the head is DONE.
    alloc_valid = 1; alloc_dest = 5'd9; step();
    alloc_valid = 0;
    cdb_valid = 1; cdb_tag = 0; cdb_value = 32'hDEAD; step();
    idle();
    rst_n = 0; step();
    rst_n = 1;
    chk("rr_wen",   64'(rf_wen), 64'd0);
    chk("rr_waddr", 64'(rf_waddr), 64'd0);
    chk("rr_wdata", 64'(rf_wdata), 64'd0);
    chk("rr_ctag",  64'(commit_tag), 64'd0);
    chk("rr_cnt",   64'(count), 64'd0);
    chk("rr_ready", 64'(alloc_ready), 64'd1);
    step();
    chk("rr_wen2",  64'(rf_wen), 64'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      alloc_valid = ($urandom_range(0, 9) < 6);
      alloc_dest  = 5'($urandom);
      cdb_valid   = $urandom_range(0, 1);
      cdb_value   = $urandom;
      flush       = ($urandom_range(0, 39) == 0);
      if (q.size() > 0 && $urandom_range(0, 7) != 0) begin
        pick = $urandom_range(0, q.size() - 1);
        cdb_tag = q[pick].tag;
      end else begin
        cdb_tag = 3'($urandom);
      end
      step();
    end
    idle();
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
